// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage.
//
// Holds the program counter, fetches one 32-bit word at a time from
// instruction memory over a req/ack handshake, and presents it to the
// decode/execute stage until that stage retires it. At retirement the next
// PC is either the sequential address or the branch target chosen by the
// control unit's jmp_select. Retired instructions are counted.
//
// Ports:
//   clk         system clock, rising edge
//   clrn        asynchronous active-low reset
//   halt        while high, no new fetch is started
//   imem_req    fetch request (high for the whole FETCH state)
//   imem_addr   word-aligned byte address of the fetch (current pc)
//   imem_ack    memory data valid on imem_rdata (only used in FETCH)
//   imem_rdata  instruction word from memory
//   ir          instruction register
//   ir_op       ir[31:26], opcode to the control unit
//   ir_pc       byte address ir was fetched from
//   ir_valid    ir holds an instruction awaiting execution
//   ex_ready    execute stage retires the valid instruction this cycle
//   jmp_select  jump taken (sampled only on a retire cycle)
//   icount      retired-instruction counter (wraps)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [5:0]  ir_op,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  input  logic        ex_ready,
  input  logic        jmp_select,
  output logic [31:0] icount
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ir_pc_q, ir_pc_d;
  logic [31:0] icount_q, icount_d;

  logic [31:0] seq_pc;
  logic [31:0] branch_off;
  logic [31:0] jmp_target;

  // Both next-PC candidates are relative to the retiring instruction's own
  // address, not to pc_q, so they stay correct however pc_q is used later.
  assign seq_pc     = ir_pc_q + 32'd4;
  assign branch_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  assign jmp_target = seq_pc + branch_off;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    ir_pc_d  = ir_pc_q;
    icount_d = icount_q;
    case (state_q)
      S_IDLE: begin
        if (!halt) state_d = S_FETCH;
      end
      S_FETCH: begin
        // halt is deliberately not looked at here: an outstanding fetch
        // always completes and halt is re-evaluated at retire.
        if (imem_ack) begin
          ir_d    = imem_rdata;
          ir_pc_d = pc_q;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (ex_ready) begin
          pc_d     = jmp_select ? jmp_target : seq_pc;
          icount_d = icount_q + 32'd1;
          state_d  = halt ? S_IDLE : S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= 32'd0;
      ir_pc_q  <= 32'd0;
      icount_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      ir_pc_q  <= ir_pc_d;
      icount_q <= icount_d;
    end
  end

  // Handshake outputs come straight from the state register so they cannot
  // glitch on input changes.
  assign imem_req  = (state_q == S_FETCH);
  assign ir_valid  = (state_q == S_VALID);
  assign imem_addr = {pc_q[31:2], 2'b00};
  assign ir        = ir_q;
  assign ir_op     = ir_q[31:26];
  assign ir_pc     = ir_pc_q;
  assign icount    = icount_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        clrn = 1'b1;
  logic        halt = 1'b1;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        ex_ready = 1'b0;
  logic        jmp_select = 1'b0;

  logic        imem_req, ir_valid;
  logic [31:0] imem_addr, ir, ir_pc, icount;
  logic [5:0]  ir_op;

  logic        w_imem_req, w_ir_valid;
  logic [31:0] w_imem_addr, w_ir, w_ir_pc, w_icount;
  logic [5:0]  w_ir_op;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (one pc per instance; both share all inputs)
  logic [31:0] m_pc, m_pc_w, m_ir, m_ir_pc, m_ir_pc_w, m_icount;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .clrn(clrn), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .ir_op(ir_op), .ir_pc(ir_pc), .ir_valid(ir_valid),
    .ex_ready(ex_ready), .jmp_select(jmp_select), .icount(icount)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .clrn(clrn), .halt(halt),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(w_ir), .ir_op(w_ir_op), .ir_pc(w_ir_pc), .ir_valid(w_ir_valid),
    .ex_ready(ex_ready), .jmp_select(jmp_select), .icount(w_icount)
  );

  task automatic model_reset();
    m_pc      = 32'h0000_0000;
    m_pc_w    = 32'hFFFF_FFFC;
    m_ir      = 32'd0;
    m_ir_pc   = 32'd0;
    m_ir_pc_w = 32'd0;
    m_icount  = 32'd0;
  endtask

  // Assumes the DUT is sampled in FETCH. Runs one complete transaction:
  // 'waits' cycles without ack, the ack cycle, 'stall' cycles of ex_ready=0,
  // then the retire cycle with the given jmp value.
  task automatic fetch_one(input int waits, input int stall,
                           input logic [31:0] instr, input logic jmp);
    int offset;
    for (int w = 0; w <= waits; w++) begin
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc || ir_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch_req: req=%b addr=%h valid=%b, required req=1 addr=%h valid=0",
                 imem_req, imem_addr, ir_valid, m_pc);
      end
      n_checks++;
      if (w_imem_req !== 1'b1 || w_imem_addr !== m_pc_w) begin
        n_fail++;
        $display("FAIL wrap_fetch_req: req=%b addr=%h, required req=1 addr=%h",
                 w_imem_req, w_imem_addr, m_pc_w);
      end
      imem_ack   = (w == waits);
      imem_rdata = (w == waits) ? instr : $urandom;
      jmp_select = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    m_ir      = instr;
    m_ir_pc   = m_pc;
    m_ir_pc_w = m_pc_w;
    for (int s = 0; s <= stall; s++) begin
      n_checks++;
      if (ir_valid !== 1'b1 || imem_req !== 1'b0 || ir !== m_ir ||
          ir_op !== m_ir[31:26] || ir_pc !== m_ir_pc) begin
        n_fail++;
        $display("FAIL valid_hold: valid=%b req=%b ir=%h op=%h ir_pc=%h, required valid=1 req=0 ir=%h op=%h ir_pc=%h",
                 ir_valid, imem_req, ir, ir_op, ir_pc, m_ir, m_ir[31:26], m_ir_pc);
      end
      n_checks++;
      if (w_ir_pc !== m_ir_pc_w || icount !== m_icount) begin
        n_fail++;
        $display("FAIL valid_state: wrap_ir_pc=%h icount=%0d, required %h %0d",
                 w_ir_pc, icount, m_ir_pc_w, m_icount);
      end
      ex_ready   = (s == stall);
      jmp_select = (s == stall) ? jmp : (s % 2 == 0);
      imem_ack   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    ex_ready   = 1'b0;
    jmp_select = 1'b0;
    imem_ack   = 1'b0;
    offset = 4 * int'($signed(m_ir[15:0]));
    m_pc   = jmp ? (m_ir_pc   + 32'd4 + 32'(offset)) : (m_ir_pc   + 32'd4);
    m_pc_w = jmp ? (m_ir_pc_w + 32'd4 + 32'(offset)) : (m_ir_pc_w + 32'd4);
    m_icount = m_icount + 32'd1;
    $display("txn ir_pc=%h ir=%h waits=%0d stall=%0d jmp=%b next_pc=%h icount=%0d",
             m_ir_pc, m_ir, waits, stall, jmp, m_pc, m_icount);
    n_checks++;
    if (icount !== m_icount || w_icount !== m_icount || ir_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL retire: icount=%0d wrap_icount=%0d valid=%b, required %0d %0d 0",
               icount, w_icount, ir_valid, m_icount, m_icount);
    end
    n_checks++;
    if (imem_req !== !halt || imem_addr !== m_pc) begin
      n_fail++;
      $display("FAIL redirect: req=%b addr=%h, required req=%b addr=%h",
               imem_req, imem_addr, !halt, m_pc);
    end
  endtask

  task automatic test_reset();
    halt = 1'b0; imem_ack = 1'b0; ex_ready = 1'b0; jmp_select = 1'b0;
    #1 clrn = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (imem_req !== 1'b0 || ir_valid !== 1'b0 || icount !== 32'd0 ||
        ir !== 32'd0 || ir_pc !== 32'd0 || imem_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_values: req=%b valid=%b icount=%0d ir=%h ir_pc=%h addr=%h, required 0 0 0 0 0 0",
               imem_req, ir_valid, icount, ir, ir_pc, imem_addr);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || w_imem_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL reset_hold: req=%b wrap_addr=%h, required 0 fffffffc",
               imem_req, w_imem_addr);
    end
    clrn = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL first_request: req=%b addr=%h, required req=1 addr=00000000",
               imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (imem_addr !== 32'(i * 4)) begin
        n_fail++;
        $display("FAIL seq_addr: addr=%h, required %h", imem_addr, 32'(i * 4));
      end
      fetch_one(0, 0, $urandom, 1'b0);
    end
    n_checks++;
    if (icount !== 32'd4) begin
      n_fail++;
      $display("FAIL seq_icount: icount=%0d, required 4", icount);
    end
  endtask

  task automatic test_jumps();
    // Entered with pc = 0x10
    fetch_one(0, 0, {6'h02, 10'h000, 16'hFFFC}, 1'b1);
    n_checks++;
    if (imem_addr !== 32'h0000_0004) begin
      n_fail++;
      $display("FAIL jump_back: addr=%h, required 00000004", imem_addr);
    end
    for (int i = 0; i < 3; i++) fetch_one(0, 0, $urandom, 1'b0);
    fetch_one(0, 0, {6'h02, 10'h155, 16'h0003}, 1'b1);
    n_checks++;
    if (imem_addr !== 32'h0000_0020) begin
      n_fail++;
      $display("FAIL jump_fwd: addr=%h, required 00000020", imem_addr);
    end
  endtask

  task automatic test_backpressure();
    // jmp_select toggles through the 5 stalled cycles, retires with 0
    logic [31:0] pc_before;
    pc_before = m_pc;
    fetch_one(0, 5, {6'h04, 10'h000, 16'h0040}, 1'b0);
    n_checks++;
    if (imem_addr !== pc_before + 32'd4) begin
      n_fail++;
      $display("FAIL stall_jmp_ignored: addr=%h, required %h", imem_addr, pc_before + 32'd4);
    end
  endtask

  task automatic test_wait_states();
    fetch_one(3, 0, $urandom, 1'b0);
    fetch_one(1, 1, $urandom, 1'b0);
  endtask

  task automatic test_halt();
    halt = 1'b1;  // raised while a fetch is outstanding
    fetch_one(2, 0, $urandom, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (imem_req !== 1'b0 || ir_valid !== 1'b0 || imem_addr !== m_pc) begin
        n_fail++;
        $display("FAIL halt_idle: req=%b valid=%b addr=%h, required 0 0 %h",
                 imem_req, ir_valid, imem_addr, m_pc);
      end
      imem_ack = 1'b1;
      @(posedge clk); #1;
    end
    imem_ack = 1'b0;
    halt = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
      n_fail++;
      $display("FAIL halt_resume: req=%b addr=%h, required 1 %h", imem_req, imem_addr, m_pc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      fetch_one($urandom_range(0, 3), $urandom_range(0, 2), $urandom,
                1'($urandom_range(0, 1)));
  endtask

  task automatic test_wrap();
    test_reset();
    n_checks++;
    if (w_imem_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_start: addr=%h, required fffffffc", w_imem_addr);
    end
    fetch_one(0, 0, $urandom, 1'b0);
    n_checks++;
    if (w_imem_addr !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL wrap_next: addr=%h, required 00000000", w_imem_addr);
    end
  endtask

  task automatic test_reset_mid_fetch();
    fetch_one(0, 0, $urandom, 1'b0);
    @(posedge clk); #1;  // still waiting for ack
    #2 clrn = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (imem_req !== 1'b0 || ir_valid !== 1'b0 || ir !== 32'd0 || ir_pc !== 32'd0 ||
        icount !== 32'd0 || imem_addr !== 32'd0 || w_imem_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL mid_reset: req=%b valid=%b ir=%h ir_pc=%h icount=%0d addr=%h waddr=%h, required reset values",
               imem_req, ir_valid, ir, ir_pc, icount, imem_addr, w_imem_addr);
    end
    halt = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    clrn = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (imem_req !== 1'b0 || ir_valid !== 1'b0 || ir !== 32'd0 || ir_pc !== 32'd0) begin
      n_fail++;
      $display("FAIL stray_ack: req=%b valid=%b ir=%h ir_pc=%h, required 0 0 0 0",
               imem_req, ir_valid, ir, ir_pc);
    end
    imem_ack = 1'b0;
    halt = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL post_reset_req: req=%b addr=%h, required 1 00000000", imem_req, imem_addr);
    end
    fetch_one(0, 0, $urandom, 1'b1);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jumps();
    test_backpressure();
    test_wait_states();
    test_halt();
    test_random();
    test_wrap();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 32-bit CPU, directly upstream of the control unit. It holds the program counter, fetches 32-bit words from instruction memory over a req/ack handshake, and presents the current instruction to the decode/execute stage. It consumes the control unit's `jmp_select` to pick the next PC at retirement, and counts retired instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- `clk` input 1: system clock; all state changes on the rising edge.
- `clrn` input 1: asynchronous, active-low reset.
- `halt` input 1: while high, no new fetch is started.
- `imem_req` output 1: fetch request to instruction memory.
- `imem_addr` output 32: byte address of the fetch; bits [1:0] are always 0.
- `imem_ack` input 1: memory has valid data on `imem_rdata` this cycle.
- `imem_rdata` input 32: instruction word from memory.
- `ir` output 32: current instruction register.
- `ir_op` output 6: equal to `ir[31:26]`; drives the control unit `op`.
- `ir_pc` output 32: byte address `ir` was fetched from.
- `ir_valid` output 1: `ir` holds an instruction awaiting execution.
- `ex_ready` input 1: execute stage accepts (retires) the valid instruction this cycle.
- `jmp_select` input 1: jump taken, from the control unit decoding `ir_op`.
- `icount` output 32: retired-instruction counter.

## Operation
- State machine with three states: IDLE, FETCH, VALID.
  - IDLE: `imem_req`=0, `ir_valid`=0. Moves to FETCH when `halt`=0; otherwise stays in IDLE.
  - FETCH: `imem_req`=1 and `imem_addr`=`pc`, held stable until `imem_ack`. On a cycle with `imem_ack`=1:
    - `ir` <= `imem_rdata` and `ir_pc` <= `pc`;
    - state moves to VALID.
  - VALID: `ir_valid`=1 and `imem_req`=0. On a cycle with `ex_ready`=1 (retire):
    - `pc` <= `jmp_select` ? target : `ir_pc`+4;
    - `icount` <= `icount`+1;
    - state moves to FETCH if `halt`=0, else to IDLE.
- Jump target is `ir_pc` + 4 + (sign-extended `ir[15:0]` << 2).
- All PC arithmetic is 32-bit modulo 2^32 and wraps silently; `icount` also wraps.
- `jmp_select` is sampled only on a retire cycle; it is ignored in every other state and cycle.
- `imem_ack` is ignored outside FETCH.
- `halt` does not abort an outstanding fetch. The fetch completes, and `halt` is re-checked at retire.
- `ir`, `ir_pc` and `ir_op` are held stable from the ack edge until the next ack edge.
- `imem_req` and `ir_valid` are decoded directly from the state register, so they are glitch-free.

## Timing
- Reset (`clrn`=0), applied immediately and asynchronously:
  - state=IDLE, `pc`=`RESET_PC`;
  - `ir`=0, `ir_pc`=0, `icount`=0;
  - `imem_req`=0, `ir_valid`=0, `imem_addr`=`RESET_PC`.
- Reset mid-fetch: `imem_req` drops in the same cycle. Any late `imem_ack` is ignored.
- First request: `imem_req` rises in the cycle after the first rising edge with `clrn`=1 and `halt`=0.
- Fetch latency: `ir_valid` rises in the cycle after the ack cycle. With an ack in the first FETCH cycle, `imem_req`-to-`ir_valid` is 1 cycle.
- Redirect latency: the new `imem_addr` appears in the cycle after the retire cycle.
- Throughput: with zero-wait memory and `ex_ready` tied high, one instruction retires every 2 cycles.
- Backpressure: with `ex_ready`=0 in VALID, the instruction stalls indefinitely and no request is issued.

## Test plan
- Reset and startup:
  - Stimulus: `clrn`=0 with `RESET_PC`=0, then release with `halt`=0.
  - Required response: during reset `imem_req`=0, `ir_valid`=0, `icount`=0. One cycle after release, `imem_req`=1 with `imem_addr`=0x0.
- Sequential fetch:
  - Stimulus: zero-wait ack, `ex_ready`=1, `jmp_select`=0.
  - Required response: `imem_addr` sequence is 0x0, 0x4, 0x8, 0xC. `ir_valid` pulses every other cycle, and `icount`=4 after the fourth retire.
- Wait states:
  - Stimulus: ack delayed 3 cycles.
  - Required response: `imem_req`=1 and `imem_addr` stay stable for 4 cycles, and `ir_valid` stays 0 until the cycle after the ack.
- Jumps:
  - Stimulus: instruction at `ir_pc`=0x10 with `ir[15:0]`=0xFFFC and `jmp_select`=1 at retire.
  - Required response: next `imem_addr`=0x04.
  - Stimulus: same with `ir[15:0]`=0x0003.
  - Required response: next `imem_addr`=0x20.
  - Stimulus: `jmp_select` toggling while `ex_ready`=0.
  - Required response: no effect.
- Backpressure and halt:
  - Stimulus: `ex_ready`=0 for 5 cycles.
  - Required response: `ir` is unchanged and `imem_req` stays 0.
  - Stimulus: `halt`=1 asserted mid-fetch.
  - Required response: the fetch completes, and after retire the state goes to IDLE with no request.
  - Stimulus: deassert `halt`.
  - Required response: a request to the correct next PC follows one cycle later.
- Wrap and reset mid-operation:
  - Stimulus: `RESET_PC`=0xFFFF_FFFC, sequential retire.
  - Required response: next `imem_addr`=0x0.
  - Stimulus: `clrn` pulsed low during FETCH, followed by a stray `imem_ack`.
  - Required response: outputs return to their reset values and the stray ack is ignored.
